// File: rtl/axi_write_slave.sv
// axi_write_slave: AXI3 write-channel responder.
// Accepts one AW burst at a time, consumes its W beats, writes valid beats to a
// word-addressed memory port with one cycle of latency, then returns a single B response.
module axi_write_slave #(
    parameter int          buswidth  = 32,
    parameter int          MEM_AW    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [3:0]              AWID,
    input  logic [31:0]             AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [3:0]              WID,
    input  logic [buswidth-1:0]     WDATA,
    input  logic [buswidth/8-1:0]   WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [3:0]              BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [buswidth-1:0]     mem_wdata,
    output logic [buswidth/8-1:0]   mem_wstrb
);
    localparam int          BYTES     = buswidth / 8;
    localparam int          BSH       = $clog2(BYTES);
    localparam logic [32:0] MEM_BYTES = 33'd1 << (MEM_AW + BSH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           id_q, id_d;
    logic [31:0]          addr_q, addr_d;
    logic [3:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic [3:0]           cnt_q, cnt_d;
    // err blocks further writes; lerr only records WLAST misuse for the response
    logic                 err_q, err_d;
    logic                 lerr_q, lerr_d;
    logic [3:0]           bid_q, bid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;
    logic [buswidth-1:0]  mem_wdata_q, mem_wdata_d;
    logic [BYTES-1:0]     mem_wstrb_q, mem_wstrb_d;

    logic [31:0] bytes_w, wrap_total, wrap_base, addr_inc, addr_step;
    logic [32:0] offset;
    logic        in_range, last_beat, beat_bad, err_next, lerr_next;
    logic        wrap_len_ok, aw_aligned, aw_err;

    assign AWREADY   = (state_q == S_IDLE) && !ARESET;
    assign WREADY    = (state_q == S_DATA);
    assign BVALID    = (state_q == S_RESP);
    assign BID       = bid_q;
    assign BRESP     = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // Next beat address: FIXED holds, INCR advances, WRAP folds back at the block end
    always_comb begin
        bytes_w    = 32'd1 << size_q;
        wrap_total = (32'(len_q) + 32'd1) << size_q;
        wrap_base  = addr_q & ~(wrap_total - 32'd1);
        addr_inc   = addr_q + bytes_w;
        case (burst_q)
            2'b00:   addr_step = addr_q;
            2'b10:   addr_step = (addr_inc == wrap_base + wrap_total) ? wrap_base : addr_inc;
            default: addr_step = addr_inc;
        endcase
    end

    // Legality of the AW request, evaluated on the live AW inputs at capture
    always_comb begin
        wrap_len_ok = (AWLEN == 4'd1) || (AWLEN == 4'd3) || (AWLEN == 4'd7) || (AWLEN == 4'd15);
        aw_aligned  = (AWADDR & ((32'd1 << AWSIZE) - 32'd1)) == 32'd0;
        aw_err      = (AWBURST == 2'b11) || (int'(AWSIZE) > BSH) ||
                      ((AWBURST == 2'b10) && (!wrap_len_ok || !aw_aligned));
    end

    // Transaction control: AW capture, per-beat write decision, response build-up
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        lerr_d      = lerr_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        offset    = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        in_range  = (addr_q >= BASE_ADDR) && (offset < MEM_BYTES);
        last_beat = (cnt_q == len_q);
        beat_bad  = (WID != id_q) || !in_range;
        err_next  = err_q | beat_bad;
        lerr_next = lerr_q | (WLAST != last_beat);

        case (state_q)
            S_IDLE: begin
                if (AWVALID && AWREADY) begin
                    id_d    = AWID;
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    size_d  = AWSIZE;
                    burst_d = AWBURST;
                    cnt_d   = 4'd0;
                    err_d   = aw_err;
                    lerr_d  = 1'b0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (WVALID) begin
                    if (!err_q && !beat_bad && (WSTRB != '0)) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = MEM_AW'(offset >> BSH);
                        mem_wdata_d = WDATA;
                        mem_wstrb_d = WSTRB;
                    end
                    err_d  = err_next;
                    lerr_d = lerr_next;
                    addr_d = addr_step;
                    cnt_d  = cnt_q + 4'd1;
                    if (last_beat) begin
                        bid_d   = id_q;
                        bresp_d = (err_next || lerr_next) ? 2'b10 : 2'b00;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (BREADY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, cleared immediately by the asynchronous reset
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            lerr_q      <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            lerr_q      <= lerr_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave: directed and randomized bursts against a burst-level reference model.
module tb_axi_write_slave;
    localparam int          BW        = 32;
    localparam int          NB        = BW / 8;
    localparam int          MEM_AW    = 8;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam longint      MEM_BYTES = (longint'(1) << MEM_AW) * NB;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [3:0]        AWID;
    logic [31:0]       AWADDR;
    logic [3:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [3:0]        WID;
    logic [BW-1:0]     WDATA;
    logic [NB-1:0]     WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [3:0]        BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [BW-1:0]     mem_wdata;
    logic [NB-1:0]     mem_wstrb;

    always #5 ACLK = ~ACLK;

    axi_write_slave #(.buswidth(BW), .MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [BW-1:0]     data;
        logic [NB-1:0]     strb;
    } wr_t;

    int  checks   = 0;
    int  failures = 0;
    wr_t got_q[$];
    wr_t exp_q[$];

    // current burst description
    logic [3:0]    b_id;
    logic [31:0]   b_addr;
    logic [3:0]    b_len;
    logic [2:0]    b_size;
    logic [1:0]    b_burst;
    logic [BW-1:0] bt_data [16];
    logic [NB-1:0] bt_strb [16];
    logic [3:0]    bt_wid  [16];
    logic          bt_wlast[16];
    int            bt_gap  [16];
    int            b_bready_wait;
    int            last_aw_wait;

    // memory-port monitor
    always @(negedge ACLK) begin
        if (mem_we === 1'b1) begin
            wr_t w;
            w.addr = mem_addr;
            w.data = mem_wdata;
            w.strb = mem_wstrb;
            got_q.push_back(w);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic finish_now(input string why);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", why);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic setup_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        b_id = id; b_addr = addr; b_len = len; b_size = size; b_burst = burst;
        b_bready_wait = 0;
        for (int i = 0; i < 16; i++) begin
            bt_data[i]  = $urandom;
            bt_strb[i]  = '1;
            bt_wid[i]   = id;
            bt_wlast[i] = (i == int'(len));
            bt_gap[i]   = 0;
        end
    endtask

    // Reference model: byte address of beat i from burst arithmetic, then the acceptance rules
    task automatic model_burst(output logic [1:0] resp);
        longint unsigned start, a, total, bound, nb;
        bit err, lerr, inr, wid_ok;
        wr_t w;
        nb    = longint'(1) << b_size;
        total = (longint'(b_len) + 1) * nb;
        start = longint'(b_addr);
        bound = (start / total) * total;
        err   = (b_burst == 2'b11) || (b_size > 3'd2) ||
                ((b_burst == 2'b10) && !(b_len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
                ((b_burst == 2'b10) && (start % nb != 0));
        lerr  = 0;
        exp_q.delete();
        for (int i = 0; i <= int'(b_len); i++) begin
            case (b_burst)
                2'b00:   a = start;
                2'b10:   a = bound + ((start - bound + longint'(i) * nb) % total);
                default: a = (start + longint'(i) * nb) & 64'h0000_0000_FFFF_FFFF;
            endcase
            inr    = (a >= longint'(BASE)) && ((a - longint'(BASE)) < MEM_BYTES);
            wid_ok = (bt_wid[i] == b_id);
            if (!err && wid_ok && inr && bt_strb[i] != '0) begin
                w.addr = MEM_AW'((a - longint'(BASE)) / NB);
                w.data = bt_data[i];
                w.strb = bt_strb[i];
                exp_q.push_back(w);
            end
            if (!wid_ok || !inr) err = 1;
            if (bt_wlast[i] != (i == int'(b_len))) lerr = 1;
        end
        resp = (err || lerr) ? 2'b10 : 2'b00;
    endtask

    // Drives one burst from a negedge; abort_beat>=0 pulses ARESET after that beat's handshake
    task automatic run_burst(input string name, input int abort_beat);
        logic [1:0] exp_resp;
        int n;
        bit bad;
        model_burst(exp_resp);
        got_q.delete();
        AWVALID = 1'b1; AWID = b_id; AWADDR = b_addr; AWLEN = b_len; AWSIZE = b_size; AWBURST = b_burst;
        n = 0;
        while (AWREADY !== 1'b1) begin
            @(negedge ACLK);
            n++;
            if (n > 50) finish_now({name, " aw"});
        end
        last_aw_wait = n;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(b_len); i++) begin
            for (int g = 0; g < bt_gap[i]; g++) begin
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1; WID = bt_wid[i]; WDATA = bt_data[i]; WSTRB = bt_strb[i]; WLAST = bt_wlast[i];
            n = 0;
            do begin
                @(negedge ACLK);
                n++;
                if (n > 50) finish_now({name, " w"});
            end while (WREADY !== 1'b1);
            @(posedge ACLK); #1;
            WVALID = 1'b0; WLAST = 1'b0;
            if (i == abort_beat) begin
                #1 ARESET = 1'b1;
                #1;
                checks++;
                if ({AWREADY, WREADY, BVALID, mem_we, BID, BRESP} !== 10'd0 || mem_addr !== '0 ||
                    mem_wdata !== '0 || mem_wstrb !== '0) begin
                    failures++;
                    $display("FAIL %s reset_clear: got awready=%b wready=%b bvalid=%b mem_we=%b bid=%h bresp=%b mem_addr=%h expected all zero",
                             name, AWREADY, WREADY, BVALID, mem_we, BID, BRESP, mem_addr);
                end
                #4 ARESET = 1'b0;
                BREADY = 1'b1;
                bad = 0;
                repeat (10) begin
                    @(negedge ACLK);
                    if (BVALID !== 1'b0) bad = 1;
                end
                BREADY = 1'b0;
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL %s no_b_after_reset: got bvalid=1 expected bvalid=0", name);
                end
                checks++;
                if (got_q.size() != abort_beat) begin
                    failures++;
                    $display("FAIL %s abort_writes: got %0d writes expected %0d", name, got_q.size(), abort_beat);
                end else begin
                    for (int k = 0; k < abort_beat; k++) begin
                        checks++;
                        if (got_q[k] !== exp_q[k]) begin
                            failures++;
                            $display("FAIL %s abort_write[%0d]: got %h expected %h", name, k, got_q[k], exp_q[k]);
                        end
                    end
                end
                return;
            end
        end
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
            if (n > 50) finish_now({name, " b"});
        end while (BVALID !== 1'b1);
        checks++;
        if (BID !== b_id || BRESP !== exp_resp) begin
            failures++;
            $display("FAIL %s bresp: got bid=%h bresp=%b expected bid=%h bresp=%b", name, BID, BRESP, b_id, exp_resp);
        end
        for (int k = 0; k < b_bready_wait; k++) begin
            @(negedge ACLK);
            checks++;
            if (BVALID !== 1'b1 || BID !== b_id || BRESP !== exp_resp || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                failures++;
                $display("FAIL %s b_hold[%0d]: got bvalid=%b bid=%h bresp=%b awready=%b wready=%b expected 1/%h/%b/0/0",
                         name, k, BVALID, BID, BRESP, AWREADY, WREADY, b_id, exp_resp);
            end
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL %s after_b: got bvalid=%b awready=%b expected bvalid=0 awready=1", name, BVALID, AWREADY);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got_q[k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL %s write[%0d]: got addr=%0d data=%h strb=%h expected addr=%0d data=%h strb=%h",
                             name, k, got_q[k].addr, got_q[k].data, got_q[k].strb, exp_q[k].addr, exp_q[k].data, exp_q[k].strb);
                end
            end
        end
        $display("burst %s: id=%h addr=%h len=%0d size=%0d type=%0d writes=%0d bresp=%b",
                 name, b_id, b_addr, b_len, b_size, b_burst, got_q.size(), BRESP);
    endtask

    task automatic test_reset;
        ARESET = 1'b1; AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        WVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, BVALID, mem_we, BID, BRESP} !== 10'd0 || mem_addr !== '0 ||
            mem_wdata !== '0 || mem_wstrb !== '0) begin
            failures++;
            $display("FAIL reset_state: got awready=%b wready=%b bvalid=%b mem_we=%b bid=%h bresp=%b expected all zero",
                     AWREADY, WREADY, BVALID, mem_we, BID, BRESP);
        end
        #2 ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got awready=%b wready=%b expected 1 0", AWREADY, WREADY);
        end
        $display("reset: done");
    endtask

    task automatic test_incr;
        setup_burst(4'h3, BASE + 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) bt_data[i] = 32'hA0 + i;
        run_burst("incr", -1);
        for (int i = 0; i < 4; i++) begin
            logic [MEM_AW-1:0] ga;
            logic [BW-1:0]     gd;
            ga = (i < got_q.size()) ? got_q[i].addr : '1;
            gd = (i < got_q.size()) ? got_q[i].data : '1;
            checks++;
            if (ga !== MEM_AW'(4 + i) || gd !== BW'(32'hA0 + i)) begin
                failures++;
                $display("FAIL incr_word[%0d]: got addr=%0d data=%h expected addr=%0d data=%h", i, ga, gd, 4 + i, 32'hA0 + i);
            end
        end
    endtask

    task automatic test_wrap;
        int wexp[4];
        wexp = '{14, 15, 12, 13};
        setup_burst(4'h7, BASE + 32'h38, 4'd3, 3'd2, 2'b10);
        run_burst("wrap", -1);
        for (int i = 0; i < 4; i++) begin
            logic [MEM_AW-1:0] ga;
            ga = (i < got_q.size()) ? got_q[i].addr : '1;
            checks++;
            if (ga !== MEM_AW'(wexp[i])) begin
                failures++;
                $display("FAIL wrap_word[%0d]: got %0d expected %0d", i, ga, wexp[i]);
            end
        end
    endtask

    task automatic test_errors;
        setup_burst(4'h1, BASE + 32'h20, 4'd1, 3'd2, 2'b11);
        run_burst("reserved_burst", -1);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL reserved_no_write: got %0d writes expected 0", got_q.size());
        end
        setup_burst(4'h2, BASE + 32'h40, 4'd1, 3'd2, 2'b01);
        bt_wlast[0] = 1'b1;
        run_burst("early_wlast", -1);
        checks++;
        if (got_q.size() != 2) begin
            failures++;
            $display("FAIL early_wlast_writes: got %0d writes expected 2", got_q.size());
        end
    endtask

    task automatic test_aw_checks;
        setup_burst(4'h4, BASE + 32'h80, 4'd1, 3'd3, 2'b01);
        run_burst("oversize", -1);
        setup_burst(4'h5, BASE + 32'h80, 4'd2, 3'd2, 2'b10);
        run_burst("wrap_len2", -1);
        setup_burst(4'h6, BASE + 32'h82, 4'd3, 3'd2, 2'b10);
        run_burst("wrap_misaligned", -1);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_misaligned_no_write: got %0d writes expected 0", got_q.size());
        end
    endtask

    task automatic test_range_id;
        logic [MEM_AW-1:0] ga;
        setup_burst(4'h8, BASE + 32'h3FC, 4'd1, 3'd2, 2'b01);
        run_burst("range_top", -1);
        ga = (got_q.size() > 0) ? got_q[0].addr : '0;
        checks++;
        if (got_q.size() != 1 || ga !== MEM_AW'(255)) begin
            failures++;
            $display("FAIL range_top_word: got count=%0d addr=%0d expected count=1 addr=255", got_q.size(), ga);
        end
        setup_burst(4'h9, BASE + 32'h100, 4'd2, 3'd2, 2'b01);
        for (int i = 0; i < 3; i++) bt_wid[i] = 4'hA;
        run_burst("wid_mismatch", -1);
        setup_burst(4'hB, BASE + 32'h200, 4'd3, 3'd2, 2'b01);
        bt_strb[1] = '0;
        run_burst("zero_strobe", -1);
    endtask

    task automatic test_backpressure;
        setup_burst(4'hC, BASE + 32'h140, 4'd3, 3'd2, 2'b01);
        bt_gap[0] = 2; bt_gap[1] = 0; bt_gap[2] = 3; bt_gap[3] = 1;
        b_bready_wait = 5;
        run_burst("backpressure", -1);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            setup_burst(4'(k), BASE + 32'(k * 16), 4'd1, 3'd2, 2'b01);
            run_burst("back_to_back", -1);
            checks++;
            if (last_aw_wait != 0) begin
                failures++;
                $display("FAIL back_to_back_aw[%0d]: got %0d wait cycles expected 0", k, last_aw_wait);
            end
        end
    endtask

    task automatic test_reset_mid;
        setup_burst(4'hD, BASE + 32'h80, 4'd3, 3'd2, 2'b01);
        run_burst("reset_mid", 1);
        $display("burst reset_mid: aborted after beat 1 writes=%0d", got_q.size());
        setup_burst(4'hE, BASE + 32'h20, 4'd0, 3'd2, 2'b01);
        run_burst("after_reset", -1);
        checks++;
        if (BRESP !== 2'b00 || got_q.size() != 1) begin
            failures++;
            $display("FAIL after_reset_ok: got bresp=%b writes=%0d expected bresp=00 writes=1", BRESP, got_q.size());
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            int r;
            logic [3:0]  len;
            logic [2:0]  size;
            logic [1:0]  burst;
            logic [31:0] addr;
            r = $urandom_range(0, 9);
            burst = (r == 0) ? 2'b00 : (r <= 5) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
            size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            len   = 4'($urandom_range(0, 15));
            if (burst == 2'b10 && $urandom_range(0, 4) != 0) len = 4'((2 << $urandom_range(0, 3)) - 1);
            addr  = BASE + $urandom_range(0, 1100);
            if ($urandom_range(0, 5) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            setup_burst(4'($urandom_range(0, 15)), addr, len, size, burst);
            for (int i = 0; i <= int'(len); i++) begin
                if ($urandom_range(0, 7) == 0) bt_strb[i] = '0;
                else bt_strb[i] = NB'($urandom_range(1, 15));
                if ($urandom_range(0, 19) == 0) bt_wid[i] = b_id ^ 4'h1;
                if ($urandom_range(0, 19) == 0) bt_wlast[i] = ~bt_wlast[i];
                bt_gap[i] = $urandom_range(0, 2);
            end
            b_bready_wait = $urandom_range(0, 3);
            run_burst("random", -1);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_errors();
        test_aw_checks();
        test_range_id();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
